// File: rtl/pic_ctl.sv
// pic_ctl: 8-input programmable interrupt controller.
// Latches request edges, applies mask and fully-nested priority, presents one
// vector at a time to the CPU and holds it until acknowledged. Mask, vector
// base and end-of-interrupt are programmed through a 4-byte port window.
module pic_ctl #(
  parameter logic [15:0] PORT_BASE    = 16'h0020,
  parameter logic [7:0]  VECTOR_RESET = 8'h08,
  parameter logic [7:0]  MASK_RESET   = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_in,
  input  logic        irq_ack,
  output logic        irq_signal,
  output logic [7:0]  irq_id,
  input  logic [15:0] port_address,
  input  logic        port_write,
  input  logic        port_read,
  input  logic [7:0]  port_out,
  output logic [7:0]  port_in,
  output logic        port_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_hist;
  logic [7:0]  r_irr;
  logic [7:0]  r_isr;
  logic [7:0]  r_imr;
  logic [4:0]  r_vbase;
  logic [2:0]  r_win;
  logic        r_irq_signal;
  logic [7:0]  r_irq_id;
  logic [7:0]  r_port_in;
  logic        r_port_ready;

  logic [7:0]  w_rise;
  logic [7:0]  w_pend;
  logic [2:0]  w_win_n;
  logic        w_win_valid;
  logic [7:0]  w_prio_mask;
  logic        w_no_block;
  logic        w_present;
  logic        w_ack_take;
  logic [7:0]  w_ack_set;
  logic [7:0]  w_eoi_clr;
  logic [15:0] w_offset;
  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_wr_cmd;
  logic [7:0]  w_rd_data;

  // Two-flop synchronizer plus one history stage for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 8'd0;
      r_sync2 <= 8'd0;
      r_hist  <= 8'd0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Per-line rising edge and "priority equal or higher than winner" mask
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign w_rise[gi]      = r_sync2[gi] & ~r_hist[gi];
      assign w_prio_mask[gi] = (3'(gi) <= w_win_n);
    end
  endgenerate

  assign w_pend     = r_irr & ~r_imr;
  assign w_no_block = ((r_isr & w_prio_mask) == 8'd0);

  // Pick the lowest-numbered unmasked pending line
  always_comb begin
    w_win_valid = 1'b0;
    w_win_n     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_win_valid = 1'b1;
        w_win_n     = 3'(i);
      end
    end
  end

  // Port window decode; subtraction wraps so addresses below the base miss
  assign w_offset = port_address - PORT_BASE;
  assign w_hit    = (w_offset < 16'd4);
  assign w_off    = w_offset[1:0];
  assign w_wr     = port_write & w_hit;
  assign w_wr_cmd = w_wr & (w_off == 2'd0);

  // Register read mux
  always_comb begin
    w_rd_data = r_irr;
    case (w_off)
      2'd0:    w_rd_data = r_isr;
      2'd1:    w_rd_data = r_imr;
      2'd2:    w_rd_data = {r_vbase, 3'b000};
      default: w_rd_data = r_irr;
    endcase
  end

  // EOI target from the in-service set as it stands before any ack this cycle
  always_comb begin
    w_eoi_clr = 8'd0;
    if (w_wr_cmd) begin
      if (port_out == 8'h20) begin
        for (int i = 7; i >= 0; i--) begin
          if (r_isr[i]) begin
            w_eoi_clr    = 8'd0;
            w_eoi_clr[i] = 1'b1;
          end
        end
      end else if (port_out[7:3] == 5'b01100) begin
        w_eoi_clr[port_out[2:0]] = 1'b1;
      end
    end
  end

  // One-hot of the line being moved from request to in-service on ack
  always_comb begin
    w_ack_set = 8'd0;
    if (w_ack_take) w_ack_set[r_win] = 1'b1;
  end

  // Presentation FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Presentation FSM next state; ack is only honoured while presenting
  always_comb begin
    w_state_next = r_state;
    w_present    = 1'b0;
    w_ack_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid && w_no_block) begin
          w_present    = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Committed vector: latched once on presentation, held until ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_signal <= 1'b0;
      r_irq_id     <= 8'd0;
      r_win        <= 3'd0;
    end else if (w_present) begin
      r_irq_signal <= 1'b1;
      r_irq_id     <= {r_vbase, w_win_n};
      r_win        <= w_win_n;
    end else if (w_ack_take) begin
      r_irq_signal <= 1'b0;
    end
  end

  // Request and in-service sets; a fresh edge beats the ack clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irr <= 8'd0;
      r_isr <= 8'd0;
    end else begin
      r_irr <= (r_irr & ~w_ack_set) | w_rise;
      r_isr <= (r_isr & ~w_eoi_clr) | w_ack_set;
    end
  end

  // Programmable mask and vector base
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_imr   <= MASK_RESET;
      r_vbase <= VECTOR_RESET[7:3];
    end else if (w_wr) begin
      if (w_off == 2'd1) r_imr   <= port_out;
      if (w_off == 2'd2) r_vbase <= port_out[7:3];
    end
  end

  // Registered read data and completion pulse for hits only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_port_in    <= 8'd0;
      r_port_ready <= 1'b0;
    end else begin
      r_port_ready <= (port_read | port_write) & w_hit;
      if (port_read && w_hit) r_port_in <= w_rd_data;
    end
  end

  assign irq_signal = r_irq_signal;
  assign irq_id     = r_irq_id;
  assign port_in    = r_port_in;
  assign port_ready = r_port_ready;

endmodule

// File: tb/tb_pic_ctl.sv
// tb_pic_ctl: table-driven register checks, directed interrupt sequences and
// a randomized run, all shadowed by a cycle-level behavioural model.
module tb_pic_ctl;

  localparam logic [15:0] BASE = 16'h0020;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq_in = 8'd0;
  logic        irq_ack = 1'b0;
  logic        irq_signal;
  logic [7:0]  irq_id;
  logic [15:0] port_address = 16'd0;
  logic        port_write = 1'b0;
  logic        port_read = 1'b0;
  logic [7:0]  port_out = 8'd0;
  logic [7:0]  port_in;
  logic        port_ready;

  int errors = 0;
  int checks = 0;

  pic_ctl #(
    .PORT_BASE(16'h0020), .VECTOR_RESET(8'h08), .MASK_RESET(8'hFF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .irq_ack(irq_ack),
    .irq_signal(irq_signal), .irq_id(irq_id), .port_address(port_address),
    .port_write(port_write), .port_read(port_read), .port_out(port_out),
    .port_in(port_in), .port_ready(port_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_irr, m_isr, m_imr, m_id, m_pin;
  logic [7:0] m_d1, m_d2, m_d3;   // irq_in as sampled 1, 2, 3 edges ago
  logic [4:0] m_vb;
  logic       m_pres, m_gap, m_rdy;
  int         m_win;

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_vb = 5'd1; m_id = 0; m_pin = 0;
    m_d1 = 0; m_d2 = 0; m_d3 = 0; m_pres = 0; m_gap = 0; m_rdy = 0; m_win = 0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs
  task automatic model_edge();
    logic [7:0] rise, pend, eoi, aset, lb;
    int  a, off, n;
    bit  hit;
    rise = m_d2 & ~m_d3;
    eoi  = 8'd0;
    aset = 8'd0;
    a    = int'(port_address);
    hit  = (a >= int'(BASE)) && (a <= int'(BASE) + 3);
    off  = a - int'(BASE);
    if (port_write && hit && off == 0) begin
      if (port_out == 8'h20)                eoi = m_isr & (~m_isr + 8'd1);
      else if (port_out[7:3] == 5'b01100)   eoi = 8'd1 << port_out[2:0];
    end
    m_rdy = (port_read || port_write) && hit;
    if (port_read && hit) begin
      case (off)
        0:       m_pin = m_isr;
        1:       m_pin = m_imr;
        2:       m_pin = {m_vb, 3'b000};
        default: m_pin = m_irr;
      endcase
    end
    pend = m_irr & ~m_imr;
    if (m_pres) begin
      if (irq_ack) begin
        aset   = 8'd1 << m_win;
        m_pres = 0;
        m_gap  = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (pend != 0) begin
      lb = pend & (~pend + 8'd1);
      n  = 0;
      while (lb > 8'd1) begin lb = lb >> 1; n++; end
      if ((int'(m_isr) & ((2 << n) - 1)) == 0) begin
        m_pres = 1;
        m_win  = n;
        m_id   = int'(m_vb) * 8 + n;
      end
    end
    m_irr = (m_irr & ~aset) | rise;
    m_isr = (m_isr & ~eoi) | aset;
    if (port_write && hit && off == 1) m_imr = port_out;
    if (port_write && hit && off == 2) m_vb  = port_out[7:3];
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq_in;
  endtask

  // One clock: model step, edge, then compare outputs 1 time unit after it
  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
    chk("sig", 8'(irq_signal), 8'(m_pres));
    if (m_pres) chk("id", irq_id, m_id);
    chk("rdy", 8'(port_ready), 8'(m_rdy));
    chk("pin", port_in, m_pin);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    port_address = BASE + 16'(off);
    port_out = d;
    port_write = 1'b1;
    cyc();
    port_write = 1'b0;
    $display("wr +%0d <= %02h", off, d);
  endtask

  task automatic rd(input int off, input logic [7:0] exp, input string name);
    port_address = BASE + 16'(off);
    port_read = 1'b1;
    cyc();
    port_read = 1'b0;
    chk(name, port_in, exp);
    chk({name, "_rdy"}, 8'(port_ready), 8'd1);
    $display("rd +%0d -> %02h (%s)", off, port_in, name);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    $display("ack");
  endtask

  task automatic wait_sig(input string name, input logic [7:0] exp_id);
    int n = 0;
    while (irq_signal !== 1'b1 && n < 12) begin cyc(); n++; end
    chk({name, "_present"}, 8'(irq_signal), 8'd1);
    chk({name, "_id"}, irq_id, exp_id);
    $display("present %s id=%02h", name, irq_id);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_rdy;
    logic [7:0]  exp_pin;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    bit a_now;
    int r, off;

    tbl[0]  = '{1, 0, 16'h0021, 8'h00, 1, 8'hFF};
    tbl[1]  = '{1, 0, 16'h0022, 8'h00, 1, 8'h08};
    tbl[2]  = '{0, 1, 16'h0022, 8'h73, 1, 8'h08};
    tbl[3]  = '{1, 0, 16'h0022, 8'h00, 1, 8'h70};
    tbl[4]  = '{1, 0, 16'h0024, 8'h00, 0, 8'h70};
    tbl[5]  = '{1, 0, 16'h001F, 8'h00, 0, 8'h70};
    tbl[6]  = '{0, 1, 16'h0023, 8'h55, 1, 8'h70};
    tbl[7]  = '{1, 0, 16'h0023, 8'h00, 1, 8'h00};
    tbl[8]  = '{0, 1, 16'h0025, 8'h00, 0, 8'h00};
    tbl[9]  = '{1, 0, 16'h0021, 8'h00, 1, 8'hFF};
    tbl[10] = '{0, 1, 16'h0022, 8'h08, 1, 8'hFF};
    tbl[11] = '{1, 0, 16'h0022, 8'h00, 1, 8'h08};
    tbl[12] = '{1, 0, 16'h0020, 8'h00, 1, 8'h00};

    // Reset
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_sig", 8'(irq_signal), 8'd0);
    chk("rst_id", irq_id, 8'd0);
    chk("rst_rdy", 8'(port_ready), 8'd0);
    chk("rst_pin", port_in, 8'd0);
    reset_n = 1'b1;
    $display("reset released");

    // Register access table
    for (int i = 0; i < 13; i++) begin
      port_address = tbl[i].addr;
      port_out     = tbl[i].data;
      port_read    = tbl[i].rd;
      port_write   = tbl[i].wr;
      cyc();
      port_read  = 1'b0;
      port_write = 1'b0;
      chk($sformatf("vec%0d_rdy", i), 8'(port_ready), 8'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_pin", i), port_in, tbl[i].exp_pin);
      $display("vec%0d addr=%04h rd=%0d wr=%0d -> rdy=%0d pin=%02h",
               i, tbl[i].addr, tbl[i].rd, tbl[i].wr, port_ready, port_in);
    end

    // Basic request with latency bound
    wr(1, 8'hFD);
    irq_in = 8'h02;
    n = 0;
    while (irq_signal !== 1'b1 && n < 8) begin
      cyc();
      n++;
      if (n == 2) irq_in = 8'h00;
    end
    irq_in = 8'h00;
    chk("basic_latency_le4", 8'(n <= 4), 8'd1);
    chk("basic_present", 8'(irq_signal), 8'd1);
    chk("basic_id", irq_id, 8'h09);
    $display("present basic id=%02h after %0d clocks", irq_id, n);
    ack();
    chk("basic_ack_drop", 8'(irq_signal), 8'd0);
    rd(0, 8'h02, "basic_isr");
    rd(3, 8'h00, "basic_irr");

    // Priority and nesting; level held high must not re-trigger
    wr(1, 8'h00);
    irq_in = 8'h09;
    wait_sig("prio0", 8'h08);
    ack();
    repeat (5) cyc();
    chk("prio_irq3_withheld", 8'(irq_signal), 8'd0);
    wr(0, 8'h20);
    rd(0, 8'h02, "nseoi1_isr");
    wr(0, 8'h20);
    wait_sig("prio3", 8'h0B);
    ack();
    repeat (6) cyc();
    chk("no_retrigger", 8'(irq_signal), 8'd0);
    wr(0, 8'h63);
    rd(0, 8'h00, "seoi3_isr");
    irq_in = 8'h00;
    repeat (4) cyc();

    // Mask and specific EOI
    wr(1, 8'hFF);
    irq_in = 8'h10;
    repeat (5) cyc();
    irq_in = 8'h00;
    chk("masked_no_sig", 8'(irq_signal), 8'd0);
    rd(3, 8'h10, "masked_irr");
    wr(1, 8'hEF);
    wait_sig("unmask4", 8'h0C);
    ack();
    rd(0, 8'h10, "isr4");
    wr(0, 8'h64);
    rd(0, 8'h00, "seoi4_isr");

    // Vector base and committed request
    wr(2, 8'h73);
    rd(2, 8'h70, "vbase");
    wr(1, 8'hFB);
    irq_in = 8'h04;
    cyc(); cyc();
    irq_in = 8'h00;
    wait_sig("vb2", 8'h72);
    wr(1, 8'hFF);
    repeat (3) cyc();
    chk("commit_sig", 8'(irq_signal), 8'd1);
    chk("commit_id", irq_id, 8'h72);
    ack();
    chk("commit_ack_drop", 8'(irq_signal), 8'd0);
    wr(0, 8'h20);
    rd(0, 8'h00, "vb_isr");

    // Asynchronous reset in the middle of a presentation
    wr(1, 8'hDF);
    irq_in = 8'h20;
    cyc(); cyc();
    irq_in = 8'h00;
    wait_sig("pre_reset", 8'h75);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("async_sig", 8'(irq_signal), 8'd0);
    chk("async_id", irq_id, 8'd0);
    $display("async reset asserted mid-request");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    rd(3, 8'h00, "post_rst_irr");
    rd(0, 8'h00, "post_rst_isr");
    rd(1, 8'hFF, "post_rst_imr");
    rd(2, 8'h08, "post_rst_vb");

    // New edge on the winning line in the ack cycle keeps it requested
    wr(1, 8'hBF);
    irq_in = 8'h40;
    cyc(); cyc();
    irq_in = 8'h00;
    wait_sig("line6", 8'h0E);
    irq_in = 8'h40;
    cyc(); cyc();
    ack();
    irq_in = 8'h00;
    rd(3, 8'h40, "setwins_irr");
    rd(0, 8'h40, "setwins_isr");
    // EOI and ack in one cycle: EOI sees the in-service set before the ack
    wr(0, 8'h20);
    wait_sig("line6_again", 8'h0E);
    port_address = BASE;
    port_out = 8'h66;
    port_write = 1'b1;
    irq_ack = 1'b1;
    cyc();
    port_write = 1'b0;
    irq_ack = 1'b0;
    $display("ack with specific EOI 66");
    rd(0, 8'h40, "eoi_ack_isr");
    rd(3, 8'h00, "eoi_ack_irr");
    wr(0, 8'h20);
    rd(0, 8'h00, "final_isr");

    // Randomized run against the model
    wr(1, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
      a_now = m_pres ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      irq_ack = a_now;
      r = int'($urandom_range(7));
      if (r <= 1) begin
        if ($urandom_range(5) == 0) begin
          port_address = 16'($urandom);
          off = 0;
        end else begin
          off = int'($urandom_range(3));
          port_address = BASE + 16'(off);
        end
        port_read  = (r == 1);
        port_write = (r == 0);
        if (off == 0) begin
          r = int'($urandom_range(9));
          port_out = (r < 5) ? 8'h20 : (r < 9) ? (8'h60 | 8'($urandom_range(7))) : 8'($urandom);
        end else if (off == 1) begin
          port_out = $urandom_range(1) ? 8'h00 : 8'($urandom);
        end else begin
          port_out = 8'($urandom);
        end
      end
      if (a_now && m_pres) $display("rand ack id=%02h", m_id);
      cyc();
      irq_ack    = 1'b0;
      port_read  = 1'b0;
      port_write = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
